// File: rtl/video_pkg.sv
// Shared types and slot-phase constants for the video RAM arbiter.
package video_pkg;

   localparam int AW = 11;
   localparam int DW = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_BG   = 2'd1,
      OWN_SPR  = 2'd2,
      OWN_CPU  = 2'd3
   } owner_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [2:0] BG_PHASE_A  = 3'd0;
   localparam logic [2:0] BG_PHASE_B  = 3'd4;
   localparam logic [2:0] CPU_PHASE_A = 3'd2;
   localparam logic [2:0] CPU_PHASE_B = 3'd6;

   function automatic logic is_bg_phase(input logic [2:0] p);
      return (p == BG_PHASE_A) || (p == BG_PHASE_B);
   endfunction

   function automatic logic is_cpu_phase(input logic [2:0] p);
      return (p == CPU_PHASE_A) || (p == CPU_PHASE_B);
   endfunction

endpackage

// File: rtl/video_ram_arbiter_if.sv
// Bus bundle between the arbiter, its three requesters, the raster timing and the RAM.
interface video_ram_arbiter_if;
   import video_pkg::*;

   logic          pclk_en;
   logic [8:0]    hpos;
   logic          hblk;
   logic          vblk;
   logic [AW-1:0] bg_addr;
   logic [DW-1:0] bg_data;
   logic          bg_valid;
   logic          spr_req;
   logic [AW-1:0] spr_addr;
   logic          spr_ack;
   logic [DW-1:0] spr_data;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic          cpu_ack;
   logic [DW-1:0] cpu_dout;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport master (
      input  pclk_en, hpos, hblk, vblk, bg_addr, spr_req, spr_addr,
             cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
      output bg_data, bg_valid, spr_ack, spr_data, cpu_ack, cpu_dout,
             ram_addr, ram_we, ram_din
   );

   modport slave (
      output pclk_en, hpos, hblk, vblk, bg_addr, spr_req, spr_addr,
             cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
      input  bg_data, bg_valid, spr_ack, spr_data, cpu_ack, cpu_dout,
             ram_addr, ram_we, ram_din
   );

endinterface

// File: rtl/vram_slot_sel.sv
// Combinational slot owner selection from raster phase, blanking and masked requests.
module vram_slot_sel
   import video_pkg::*;
(
   input  logic [2:0] phase_i,
   input  logic       hblk_i,
   input  logic       vblk_i,
   input  logic       spr_req_i,
   input  logic       cpu_req_i,
   input  logic       spr_mask_i,
   input  logic       cpu_mask_i,
   output owner_t     owner_o
);

   logic spr_ok_s;
   logic cpu_ok_s;

   assign spr_ok_s = spr_req_i && !spr_mask_i;
   assign cpu_ok_s = cpu_req_i && !cpu_mask_i;

   // Vertical blanking is CPU-only; BG phases are dropped during horizontal blanking.
   always_comb begin
      owner_o = OWN_NONE;
      if (vblk_i) begin
         if (cpu_ok_s) owner_o = OWN_CPU;
         else          owner_o = OWN_NONE;
      end else if (!hblk_i && is_bg_phase(phase_i)) begin
         owner_o = OWN_BG;
      end else if (is_cpu_phase(phase_i)) begin
         if (cpu_ok_s)      owner_o = OWN_CPU;
         else if (spr_ok_s) owner_o = OWN_SPR;
         else               owner_o = OWN_NONE;
      end else begin
         if (spr_ok_s)      owner_o = OWN_SPR;
         else if (cpu_ok_s) owner_o = OWN_CPU;
         else               owner_o = OWN_NONE;
      end
   end

endmodule

// File: rtl/video_ram_arbiter.sv
// Slot arbiter: one RAM access per pixel-clock enable, IDLE -> CMD -> DATA per slot.
module video_ram_arbiter
   import video_pkg::*;
(
   input  logic                 mclk_i,
   input  logic                 rst_n_i,
   video_ram_arbiter_if.master  bus
);

   state_t        state_q, state_d;
   owner_t        owner_q, owner_d;
   owner_t        sel_owner_s;
   logic          cpu_wr_q, cpu_wr_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_din_q, ram_din_d;
   logic          ram_we_q, ram_we_d;
   logic [DW-1:0] bg_data_q, bg_data_d;
   logic          bg_valid_q, bg_valid_d;
   logic [DW-1:0] spr_data_q, spr_data_d;
   logic          spr_ack_q, spr_ack_d;
   logic [DW-1:0] cpu_dout_q, cpu_dout_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          spr_mask_s, cpu_mask_s, grant_s;

   // A requester still holds REQ through its own access and the cycle after ACK.
   assign spr_mask_s = ((state_q != ST_IDLE) && (owner_q == OWN_SPR)) || spr_ack_q;
   assign cpu_mask_s = ((state_q != ST_IDLE) && (owner_q == OWN_CPU)) || cpu_ack_q;
   assign grant_s    = bus.pclk_en && (state_q == ST_IDLE) && (sel_owner_s != OWN_NONE);

   vram_slot_sel u_slot_sel (
      .phase_i    (bus.hpos[2:0]),
      .hblk_i     (bus.hblk),
      .vblk_i     (bus.vblk),
      .spr_req_i  (bus.spr_req),
      .cpu_req_i  (bus.cpu_req),
      .spr_mask_i (spr_mask_s),
      .cpu_mask_i (cpu_mask_s),
      .owner_o    (sel_owner_s)
   );

   // Next-state and output decode for the slot FSM.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cpu_wr_d   = cpu_wr_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      ram_we_d   = 1'b0;
      bg_data_d  = bg_data_q;
      bg_valid_d = 1'b0;
      spr_data_d = spr_data_q;
      spr_ack_d  = 1'b0;
      cpu_dout_d = cpu_dout_q;
      cpu_ack_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_s) begin
               state_d  = ST_CMD;
               owner_d  = sel_owner_s;
               cpu_wr_d = 1'b0;
               case (sel_owner_s)
                  OWN_BG:  ram_addr_d = bus.bg_addr;
                  OWN_SPR: ram_addr_d = bus.spr_addr;
                  OWN_CPU: begin
                     ram_addr_d = bus.cpu_addr;
                     ram_din_d  = bus.cpu_din;
                     ram_we_d   = bus.cpu_we;
                     cpu_wr_d   = bus.cpu_we;
                  end
                  default: ram_addr_d = ram_addr_q;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: state_d = ST_DATA;
         ST_DATA: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            case (owner_q)
               OWN_BG: begin
                  bg_data_d  = bus.ram_dout;
                  bg_valid_d = 1'b1;
               end
               OWN_SPR: begin
                  spr_data_d = bus.ram_dout;
                  spr_ack_d  = 1'b1;
               end
               OWN_CPU: begin
                  cpu_ack_d = 1'b1;
                  if (!cpu_wr_q) cpu_dout_d = bus.ram_dout;
                  else           cpu_dout_d = cpu_dout_q;
               end
               default: owner_d = OWN_NONE;
            endcase
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   // State, owner and every registered output.
   always_ff @(posedge mclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_NONE;
         cpu_wr_q   <= 1'b0;
         ram_addr_q <= {AW{1'b0}};
         ram_din_q  <= {DW{1'b0}};
         ram_we_q   <= 1'b0;
         bg_data_q  <= {DW{1'b0}};
         bg_valid_q <= 1'b0;
         spr_data_q <= {DW{1'b0}};
         spr_ack_q  <= 1'b0;
         cpu_dout_q <= {DW{1'b0}};
         cpu_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cpu_wr_q   <= cpu_wr_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         ram_we_q   <= ram_we_d;
         bg_data_q  <= bg_data_d;
         bg_valid_q <= bg_valid_d;
         spr_data_q <= spr_data_d;
         spr_ack_q  <= spr_ack_d;
         cpu_dout_q <= cpu_dout_d;
         cpu_ack_q  <= cpu_ack_d;
      end
   end

   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_din  = ram_din_q;
   assign bus.ram_we   = ram_we_q;
   assign bus.bg_data  = bg_data_q;
   assign bus.bg_valid = bg_valid_q;
   assign bus.spr_data = spr_data_q;
   assign bus.spr_ack  = spr_ack_q;
   assign bus.cpu_dout = cpu_dout_q;
   assign bus.cpu_ack  = cpu_ack_q;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Self-checking bench: vector table, reset abort sequence and random raster stress with a scoreboard.
module tb_video_ram_arbiter;
   import video_pkg::*;

   logic mclk = 1'b0;
   logic rst_n;
   always #5 mclk = ~mclk;

   video_ram_arbiter_if bus();

   video_ram_arbiter dut (
      .mclk_i  (mclk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   function automatic logic [7:0] pat(input logic [10:0] a);
      return a[7:0] ^ {a[10:8], 5'h15};
   endfunction

   // Synchronous RAM, read-first, data one MCLK after address
   logic [7:0] ram_mem [0:2047];
   bit         ram_wr  [0:2047];
   always @(posedge mclk) begin
      if (bus.ram_we === 1'b1) begin
         ram_mem[bus.ram_addr] <= bus.ram_din;
         ram_wr[bus.ram_addr]  <= 1'b1;
      end
      bus.ram_dout <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr] : pat(bus.ram_addr);
   end

   int cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   typedef struct { logic [7:0] data; int due; } exp_t;
   typedef struct { logic [10:0] addr; logic [7:0] din; } wr_t;
   typedef struct {
      logic [8:0] hpos; logic hblk; logic vblk;
      logic spr_set; logic [10:0] spr_addr;
      logic cpu_set; logic cpu_we; logic [10:0] cpu_addr; logic [7:0] cpu_din;
      int exp_own;
   } vec_t;

   exp_t q_bg[$], q_spr[$], q_cpu[$];
   wr_t  q_wr[$];
   logic [7:0]  sh_mem [0:2047];
   bit          sh_wr  [0:2047];
   bit          spr_granted, cpu_granted, spr_drop, cpu_drop;
   logic [7:0]  m_cpu_dout;
   logic [10:0] m_last_addr;
   int          seen_owner;
   int          checks = 0;
   int          errors = 0;
   localparam int NV = 19;
   vec_t        vt [NV];

   function automatic logic [7:0] sh_rd(input logic [10:0] a);
      return sh_wr[a] ? sh_mem[a] : pat(a);
   endfunction

   function automatic vec_t mk(input logic [8:0] h, input logic hb, input logic vb,
                               input logic ss, input logic [10:0] sa,
                               input logic cs, input logic cw, input logic [10:0] ca,
                               input logic [7:0] cd, input int eo);
      vec_t v;
      v.hpos = h; v.hblk = hb; v.vblk = vb; v.spr_set = ss; v.spr_addr = sa;
      v.cpu_set = cs; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_din = cd; v.exp_own = eo;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=strobe expected=none", name);
   endtask

   // One MCLK: requester drops, scoreboard compare of strobes and write strobes
   task automatic tick();
      exp_t e;
      wr_t  w;
      @(negedge mclk);
      if (spr_drop) begin bus.spr_req = 1'b0; spr_drop = 1'b0; spr_granted = 1'b0; end
      if (cpu_drop) begin bus.cpu_req = 1'b0; cpu_drop = 1'b0; cpu_granted = 1'b0; end
      if (bus.bg_valid === 1'b1) begin
         seen_owner = 1;
         if (q_bg.size() == 0) fail("bg_unexpected");
         else begin
            e = q_bg.pop_front();
            chk("bg_data", 32'(bus.bg_data), 32'(e.data));
            chk("bg_time", 32'(cyc), 32'(e.due));
         end
      end
      if (bus.spr_ack === 1'b1) begin
         seen_owner = 2;
         spr_drop = 1'b1;
         if (q_spr.size() == 0) fail("spr_unexpected");
         else begin
            e = q_spr.pop_front();
            chk("spr_data", 32'(bus.spr_data), 32'(e.data));
            chk("spr_time", 32'(cyc), 32'(e.due));
         end
      end
      if (bus.cpu_ack === 1'b1) begin
         seen_owner = 3;
         cpu_drop = 1'b1;
         if (q_cpu.size() == 0) fail("cpu_unexpected");
         else begin
            e = q_cpu.pop_front();
            chk("cpu_dout", 32'(bus.cpu_dout), 32'(e.data));
            chk("cpu_time", 32'(cyc), 32'(e.due));
         end
      end
      if (bus.ram_we === 1'b1) begin
         if (q_wr.size() == 0) fail("ram_we_unexpected");
         else begin
            w = q_wr.pop_front();
            chk("wr_addr", 32'(bus.ram_addr), 32'(w.addr));
            chk("wr_din", 32'(bus.ram_din), 32'(w.din));
         end
      end
   endtask

   // Reference slot rule evaluated when PCLK_EN is driven
   task automatic predict(output int own);
      logic [1:0] p;
      bit   spr_ok, cpu_ok;
      exp_t e;
      wr_t  w;
      p = bus.hpos[1:0];
      spr_ok = bus.spr_req && !spr_granted;
      cpu_ok = bus.cpu_req && !cpu_granted;
      if (bus.vblk)                        own = cpu_ok ? 3 : 0;
      else if (!bus.hblk && p == 2'b00)    own = 1;
      else if (p == 2'b10)                 own = cpu_ok ? 3 : (spr_ok ? 2 : 0);
      else                                 own = spr_ok ? 2 : (cpu_ok ? 3 : 0);
      e.due = cyc + 3;
      case (own)
         1: begin
            e.data = sh_rd(bus.bg_addr); q_bg.push_back(e); m_last_addr = bus.bg_addr;
         end
         2: begin
            e.data = sh_rd(bus.spr_addr); q_spr.push_back(e); m_last_addr = bus.spr_addr;
            spr_granted = 1'b1;
         end
         3: begin
            cpu_granted = 1'b1;
            m_last_addr = bus.cpu_addr;
            if (bus.cpu_we) begin
               sh_mem[bus.cpu_addr] = bus.cpu_din;
               sh_wr[bus.cpu_addr]  = 1'b1;
               w.addr = bus.cpu_addr; w.din = bus.cpu_din;
               q_wr.push_back(w);
            end else begin
               m_cpu_dout = sh_rd(bus.cpu_addr);
            end
            e.data = m_cpu_dout; q_cpu.push_back(e);
         end
         default: ;
      endcase
   endtask

   task automatic slot(input logic [8:0] h, input logic hb, input logic vb, input int period);
      int own;
      bus.hpos = h; bus.hblk = hb; bus.vblk = vb;
      bus.bg_addr = 11'($urandom_range(0, 2047));
      bus.pclk_en = 1'b1;
      predict(own);
      seen_owner = 0;
      tick();
      bus.pclk_en = 1'b0;
      repeat (period - 1) tick();
   endtask

   task automatic req_spr(input logic [10:0] a);
      if (!bus.spr_req) begin bus.spr_addr = a; bus.spr_req = 1'b1; end
   endtask

   task automatic req_cpu(input logic we, input logic [10:0] a, input logic [7:0] d);
      if (!bus.cpu_req) begin
         bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_req = 1'b1;
      end
   endtask

   initial begin
      vt[0]  = mk(9'd0,   1'b0, 1'b0, 1'b1, 11'h010, 1'b0, 1'b0, 11'h000, 8'h00, 1);
      vt[1]  = mk(9'd1,   1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 2);
      vt[2]  = mk(9'd2,   1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 0);
      vt[3]  = mk(9'd3,   1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 0);
      vt[4]  = mk(9'd4,   1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1);
      vt[5]  = mk(9'd5,   1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 0);
      vt[6]  = mk(9'd6,   1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 0);
      vt[7]  = mk(9'd7,   1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 0);
      vt[8]  = mk(9'd10,  1'b0, 1'b0, 1'b1, 11'h055, 1'b1, 1'b0, 11'h7FF, 8'h00, 3);
      vt[9]  = mk(9'd11,  1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 2);
      vt[10] = mk(9'd17,  1'b1, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 11'h0AB, 8'h00, 3);
      vt[11] = mk(9'd16,  1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 0);
      vt[12] = mk(9'd0,   1'b0, 1'b1, 1'b1, 11'h066, 1'b1, 1'b1, 11'h123, 8'h5A, 3);
      vt[13] = mk(9'd1,   1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 0);
      vt[14] = mk(9'd5,   1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 1'b0, 11'h123, 8'h00, 3);
      vt[15] = mk(9'd511, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 2);
      vt[16] = mk(9'd0,   1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1);
      vt[17] = mk(9'd300, 1'b1, 1'b0, 1'b1, 11'h077, 1'b0, 1'b0, 11'h000, 8'h00, 2);
      vt[18] = mk(9'd301, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 11'h200, 8'h3C, 3);

      rst_n = 1'b0;
      bus.pclk_en = 1'b0; bus.hpos = 9'd0; bus.hblk = 1'b0; bus.vblk = 1'b0;
      bus.bg_addr = 11'd0; bus.spr_req = 1'b0; bus.spr_addr = 11'd0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 11'd0; bus.cpu_din = 8'd0;
      spr_granted = 1'b0; cpu_granted = 1'b0; spr_drop = 1'b0; cpu_drop = 1'b0;
      m_cpu_dout = 8'd0; m_last_addr = 11'd0; seen_owner = 0;
      repeat (3) tick();
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst_ram_we",   32'(bus.ram_we),   32'd0);
      chk("rst_ram_din",  32'(bus.ram_din),  32'd0);
      chk("rst_bg_valid", 32'(bus.bg_valid), 32'd0);
      chk("rst_spr_ack",  32'(bus.spr_ack),  32'd0);
      chk("rst_cpu_ack",  32'(bus.cpu_ack),  32'd0);
      chk("rst_bg_data",  32'(bus.bg_data),  32'd0);
      chk("rst_spr_data", 32'(bus.spr_data), 32'd0);
      chk("rst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < NV; i++) begin
         if (vt[i].spr_set) req_spr(vt[i].spr_addr);
         if (vt[i].cpu_set) req_cpu(vt[i].cpu_we, vt[i].cpu_addr, vt[i].cpu_din);
         slot(vt[i].hpos, vt[i].hblk, vt[i].vblk, 4);
         chk($sformatf("vec%0d_owner", i), 32'(seen_owner), 32'(vt[i].exp_own));
         chk($sformatf("vec%0d_addr_hold", i), 32'(bus.ram_addr), 32'(m_last_addr));
      end

      // Reset during the CMD cycle of a CPU write aborts it
      req_cpu(1'b1, 11'h321, 8'hC3);
      bus.hpos = 9'd3; bus.hblk = 1'b0; bus.vblk = 1'b1;
      bus.pclk_en = 1'b1;
      predict(seen_owner);
      tick();
      bus.pclk_en = 1'b0;
      chk("abort_we_before", 32'(bus.ram_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_we_drop",   32'(bus.ram_we),   32'd0);
      chk("abort_addr_zero", 32'(bus.ram_addr), 32'd0);
      chk("abort_dout_zero", 32'(bus.cpu_dout), 32'd0);
      q_cpu.delete();
      cpu_granted = 1'b0; m_cpu_dout = 8'd0; m_last_addr = 11'd0;
      sh_wr[11'h321] = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      slot(9'd4, 1'b0, 1'b1, 4);
      chk("abort_retry_owner", 32'(seen_owner), 32'd3);
      req_cpu(1'b0, 11'h321, 8'h00);
      slot(9'd5, 1'b0, 1'b1, 4);
      chk("abort_readback_owner", 32'(seen_owner), 32'd3);

      // Random raster stress, pixel enables 3 or 4 MCLK apart
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) req_spr(11'($urandom_range(0, 2047)));
         if ($urandom_range(0, 2) == 0)
            req_cpu(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)));
         slot(9'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), int'($urandom_range(3, 4)));
         chk("stress_addr_hold", 32'(bus.ram_addr), 32'(m_last_addr));
      end

      for (int n = 0; n < 40 && (bus.spr_req || bus.cpu_req); n++)
         slot(9'(n + 1), 1'b0, 1'b0, 4);
      chk("drain_req_idle", 32'({bus.spr_req, bus.cpu_req}), 32'd0);
      repeat (4) tick();
      chk("drain_q_bg",  32'(q_bg.size()),  32'd0);
      chk("drain_q_spr", 32'(q_spr.size()), 32'd0);
      chk("drain_q_cpu", 32'(q_cpu.size()), 32'd0);
      chk("drain_q_wr",  32'(q_wr.size()),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
